// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: channel opcodes, master FSM state codes and
// the A-opcode selection rule.
package tl_ul_pkg;

    localparam logic [3:0] A_PUT_FULL    = 4'h0;
    localparam logic [3:0] A_PUT_PARTIAL = 4'h1;
    localparam logic [3:0] A_GET         = 4'h4;

    localparam logic [3:0] D_ACK      = 4'h0;
    localparam logic [3:0] D_ACK_DATA = 4'h1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_A_REQ  = 2'd1;
    localparam state_t ST_D_WAIT = 2'd2;
    localparam state_t ST_RSP    = 2'd3;

    // A full-mask write is a PutFullData; anything narrower is a partial put.
    function automatic logic [3:0] a_opcode_for(input logic write, input logic [3:0] mask);
        if (!write)
            return A_GET;
        else if (mask == 4'hF)
            return A_PUT_FULL;
        else
            return A_PUT_PARTIAL;
    endfunction

endpackage

// File: rtl/tl_ul_master_if.sv
// TileLink-UL A/D channel bundle between the master and the register-file slave.
interface tl_ul_master_if;

    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_opcode;
    logic [3:0]  a_mask;
    logic [3:0]  a_address;
    logic [31:0] a_data;

    logic        d_valid;
    logic        d_ready;
    logic [3:0]  d_opcode;
    logic [31:0] d_data;

    modport master (
        output a_valid, a_opcode, a_mask, a_address, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_mask, a_address, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_data
    );

endinterface

// File: rtl/tl_ul_master.sv
// Single-outstanding TileLink-UL master: one CPU command becomes one A request,
// and the matching D response (or a timeout) becomes one CPU response.
module tl_ul_master
    import tl_ul_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [3:0]     cmd_addr,
    input  logic [3:0]     cmd_mask,
    input  logic [31:0]    cmd_wdata,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [31:0]    rsp_rdata,
    output logic           rsp_err,
    tl_ul_master_if.master tl
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        is_read;
    logic [7:0]  wait_cnt;
    logic [3:0]  a_opcode_q;
    logic [3:0]  a_mask_q;
    logic [3:0]  a_address_q;
    logic [31:0] a_data_q;
    logic [3:0]  d_expected;

    assign d_expected = is_read ? D_ACK_DATA : D_ACK;

    // Handshake outputs are pure state decodes, so no input reaches an output
    // combinationally.
    assign cmd_ready    = (state == ST_IDLE);
    assign tl.a_valid   = (state == ST_A_REQ);
    assign tl.d_ready   = (state == ST_D_WAIT);
    assign rsp_valid    = (state == ST_RSP);

    assign tl.a_opcode  = a_opcode_q;
    assign tl.a_mask    = a_mask_q;
    assign tl.a_address = a_address_q;
    assign tl.a_data    = a_data_q;

    // NOTE: every register here is updated with non-blocking assignments so all
    // of them see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            is_read     <= 1'b0;
            wait_cnt    <= 8'd0;
            a_opcode_q  <= 4'h0;
            a_mask_q    <= 4'h0;
            a_address_q <= 4'h0;
            a_data_q    <= 32'h0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        a_opcode_q  <= a_opcode_for(cmd_write, cmd_mask);
                        a_mask_q    <= cmd_mask;
                        a_address_q <= cmd_addr;
                        a_data_q    <= cmd_wdata;
                        is_read     <= !cmd_write;
                        state       <= ST_A_REQ;
                    end
                end
                ST_A_REQ: begin
                    if (tl.a_ready) begin
                        wait_cnt <= 8'd0;
                        state    <= ST_D_WAIT;
                    end
                end
                ST_D_WAIT: begin
                    // A response in the expiry cycle still counts as a response.
                    if (tl.d_valid) begin
                        rsp_err   <= (tl.d_opcode != d_expected);
                        rsp_rdata <= (is_read && tl.d_opcode == D_ACK_DATA) ? tl.d_data : 32'h0;
                        state     <= ST_RSP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                        state     <= ST_RSP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_ul_master.sv
// Randomised transaction-level check of tl_ul_master against a phase/expectation
// model, with directed cases for opcode selection, errors, timeout and reset.
module tb_tl_ul_master;

    localparam int TIMEOUT = 6;

    typedef enum int {P_IDLE, P_A, P_D, P_RSP} phase_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_write, cmd_ready;
    logic [3:0]  cmd_addr, cmd_mask;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    tl_ul_master_if bus();

    tl_ul_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_mask  (cmd_mask),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .tl        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of what the outputs must be: the current protocol phase and the
    // transaction-level expectations for the A fields and the response.
    phase_e      ph = P_IDLE;
    logic        cmp_en = 1'b0;
    logic [3:0]  exp_op, exp_mask, exp_addr;
    logic [31:0] exp_data, exp_rdata;
    logic        exp_err;

    logic [3:0]  seen_a_op, seen_a_mask;
    logic [31:0] seen_a_data, seen_rdata;
    logic        seen_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_opcode(input logic wr, input logic [3:0] mask);
        if (!wr) return 4'h4;
        if (mask == 4'hF) return 4'h0;
        return 4'h1;
    endfunction

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("handshake {cmd_ready,a_valid,d_ready,rsp_valid}",
                  {28'h0, cmd_ready, bus.a_valid, bus.d_ready, rsp_valid},
                  {28'h0, ph == P_IDLE, ph == P_A, ph == P_D, ph == P_RSP});
            if (ph == P_A || ph == P_D) begin
                check("a_fields {opcode,mask,address}",
                      {20'h0, bus.a_opcode, bus.a_mask, bus.a_address},
                      {20'h0, exp_op, exp_mask, exp_addr});
                check("a_data", bus.a_data, exp_data);
            end
            if (ph == P_RSP) begin
                check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
                check("rsp_rdata", rsp_rdata, exp_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic wr, input logic [3:0] addr, input logic [3:0] mask,
                           input logic [31:0] wdata, input int a_stall, input int d_delay,
                           input logic [3:0] d_op, input logic [31:0] d_dat, input int rsp_stall);
        bit timed_out;
        int n;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_mask  = mask;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_mask  = 4'($urandom);
        cmd_wdata = $urandom;
        exp_op   = model_opcode(wr, mask);
        exp_mask = mask;
        exp_addr = addr;
        exp_data = wdata;
        ph = P_A;
        for (int i = 0; i <= a_stall; i++) begin
            bus.a_ready  = (i == a_stall);
            bus.d_valid  = (i != a_stall) && ($urandom_range(0, 1) == 1);
            bus.d_opcode = wr ? 4'h0 : 4'h1;
            bus.d_data   = $urandom;
            @(negedge clk);
            if (i == 0) begin
                seen_a_op   = bus.a_opcode;
                seen_a_mask = bus.a_mask;
                seen_a_data = bus.a_data;
            end
            tick();
        end
        bus.a_ready = 1'b0;
        bus.d_valid = 1'b0;
        ph = P_D;
        timed_out = (d_delay >= TIMEOUT);
        n = timed_out ? TIMEOUT : d_delay;
        for (int i = 0; i < n; i++) tick();
        if (!timed_out) begin
            bus.d_valid  = 1'b1;
            bus.d_opcode = d_op;
            bus.d_data   = d_dat;
            tick();
            bus.d_valid = 1'b0;
        end
        exp_err   = timed_out ? 1'b1 : (d_op != (wr ? 4'h0 : 4'h1));
        exp_rdata = (!exp_err && !wr) ? d_dat : 32'h0;
        ph = P_RSP;
        for (int i = 0; i <= rsp_stall; i++) begin
            rsp_ready    = (i == rsp_stall);
            bus.d_valid  = (timed_out && i == 0) || ($urandom_range(0, 1) == 1);
            bus.d_opcode = wr ? 4'h0 : 4'h1;
            bus.d_data   = $urandom | 32'h1;
            @(negedge clk);
            if (i == 0) begin
                seen_err   = rsp_err;
                seen_rdata = rsp_rdata;
            end
            tick();
        end
        rsp_ready   = 1'b0;
        bus.d_valid = 1'b0;
        ph = P_IDLE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_mask = 4'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        bus.a_ready = 1'b0; bus.d_valid = 1'b0; bus.d_opcode = 4'h0; bus.d_data = 32'h0;

        #3;
        check("reset handshake {cmd_ready,a_valid,d_ready,rsp_valid}",
              {28'h0, cmd_ready, bus.a_valid, bus.d_ready, rsp_valid}, 32'h8);
        check("reset a_fields", {20'h0, bus.a_opcode, bus.a_mask, bus.a_address}, 32'h0);
        check("reset a_data", bus.a_data, 32'h0);
        check("reset rsp", {rsp_rdata[30:0], rsp_err}, 32'h0);

        tick();
        rst_n = 1'b1;
        ph = P_IDLE;
        cmp_en = 1'b1;
        tick();

        run_txn(1'b1, 4'h2, 4'hF, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 0);
        check("full write a_opcode", {28'h0, seen_a_op}, 32'h0);
        check("full write a_data", seen_a_data, 32'hDEADBEEF);
        check("full write rsp {err,rdata}", {seen_rdata[30:0], seen_err}, 32'h0);

        run_txn(1'b1, 4'h3, 4'h5, 32'h0BADF00D, 0, 1, 4'h0, 32'h0, 0);
        check("partial write a_opcode", {28'h0, seen_a_op}, 32'h1);
        check("partial write a_mask", {28'h0, seen_a_mask}, 32'h5);
        check("partial write rsp_err", {31'h0, seen_err}, 32'h0);

        run_txn(1'b0, 4'h1, 4'hF, 32'h0, 0, 0, 4'h1, 32'h12345678, 0);
        check("read a_opcode", {28'h0, seen_a_op}, 32'h4);
        check("read rsp_rdata", seen_rdata, 32'h12345678);
        check("read rsp_err", {31'h0, seen_err}, 32'h0);

        run_txn(1'b1, 4'h9, 4'hC, 32'hCAFE0001, 3, 2, 4'h0, 32'h0, 2);

        run_txn(1'b0, 4'h4, 4'hF, 32'h0, 0, 1, 4'h0, 32'h55AA55AA, 0);
        check("read with AccessAck rsp_err", {31'h0, seen_err}, 32'h1);
        check("read with AccessAck rsp_rdata", seen_rdata, 32'h0);

        run_txn(1'b0, 4'h5, 4'hF, 32'h0, 1, TIMEOUT, 4'h1, 32'h0, 1);
        check("timeout rsp_err", {31'h0, seen_err}, 32'h1);
        check("timeout rsp_rdata", seen_rdata, 32'h0);

        run_txn(1'b0, 4'h6, 4'hF, 32'h0, 0, TIMEOUT - 1, 4'h1, 32'hA5A5F00F, 0);
        check("expiry-cycle response rsp_err", {31'h0, seen_err}, 32'h0);
        check("expiry-cycle response rsp_rdata", seen_rdata, 32'hA5A5F00F);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h7; cmd_mask = 4'h3; cmd_wdata = 32'hAAAA5555;
        tick();
        cmd_valid = 1'b0;
        exp_op = 4'h1; exp_mask = 4'h3; exp_addr = 4'h7; exp_data = 32'hAAAA5555;
        ph = P_A;
        bus.a_ready = 1'b1;
        tick();
        bus.a_ready = 1'b0;
        ph = P_D;
        tick();
        tick();
        cmp_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid-reset handshake {cmd_ready,a_valid,d_ready,rsp_valid}",
              {28'h0, cmd_ready, bus.a_valid, bus.d_ready, rsp_valid}, 32'h8);
        check("mid-reset a_fields", {20'h0, bus.a_opcode, bus.a_mask, bus.a_address}, 32'h0);
        check("mid-reset a_data", bus.a_data, 32'h0);
        check("mid-reset rsp", {rsp_rdata[30:0], rsp_err}, 32'h0);
        bus.d_valid = 1'b1; bus.d_opcode = 4'h0;
        tick();
        bus.d_valid = 1'b0;
        rst_n = 1'b1;
        ph = P_IDLE;
        cmp_en = 1'b1;
        tick();
        run_txn(1'b0, 4'h8, 4'hF, 32'h0, 0, 0, 4'h1, 32'h0F0F1234, 0);
        check("post-reset read rsp_rdata", seen_rdata, 32'h0F0F1234);

        for (int t = 0; t < 60; t++) begin
            logic wr;
            wr = 1'($urandom);
            run_txn(wr, 4'($urandom), ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom),
                    $urandom, $urandom_range(0, 3), $urandom_range(0, TIMEOUT + 1),
                    ($urandom_range(0, 3) == 0) ? (wr ? 4'h1 : 4'h0) : (wr ? 4'h0 : 4'h1),
                    $urandom, $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
